// File: rtl/instr_encode_writer_pkg.sv
// ============================================================================
// Module : instr_encode_writer_pkg
// Brief  : RV32I opcodes, encoder format enum and request struct shared by
//          the instruction encode/writer block.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package instr_encode_writer_pkg;

    localparam logic [6:0] c_op_lui   = 7'b0110111;
    localparam logic [6:0] c_op_auipc = 7'b0010111;
    localparam logic [6:0] c_op_jal   = 7'b1101111;
    localparam logic [6:0] c_op_jalr  = 7'b1100111;
    localparam logic [6:0] c_op_br    = 7'b1100011;
    localparam logic [6:0] c_op_load  = 7'b0000011;
    localparam logic [6:0] c_op_store = 7'b0100011;
    localparam logic [6:0] c_op_imm   = 7'b0010011;
    localparam logic [6:0] c_op_reg   = 7'b0110011;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_ISH,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_BAD
    } instr_fmt_t;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } encode_req_t;

    // Shift-immediate ops keep funct7 in the upper bits instead of imm[11:5].
    function automatic instr_fmt_t opcode_fmt(input logic [6:0] op, input logic [2:0] f3);
        instr_fmt_t fmt;
        case (op)
            c_op_reg:                fmt = FMT_R;
            c_op_imm:                fmt = (f3 == 3'b001 || f3 == 3'b101) ? FMT_ISH : FMT_I;
            c_op_load, c_op_jalr:    fmt = FMT_I;
            c_op_store:              fmt = FMT_S;
            c_op_br:                 fmt = FMT_B;
            c_op_lui, c_op_auipc:    fmt = FMT_U;
            c_op_jal:                fmt = FMT_J;
            default:                 fmt = FMT_BAD;
        endcase
        return fmt;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rv32i_encoder.sv
// ============================================================================
// Module : rv32i_encoder
// Brief  : Combinational RV32I request -> 32-bit instruction word encoder.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv32i_encoder
    import instr_encode_writer_pkg::*;
(
    input  encode_req_t req,
    output logic [31:0] word,
    output instr_fmt_t  fmt
);

    instr_fmt_t  w_fmt;
    logic [31:0] w_word;

    always_comb begin
        w_fmt  = opcode_fmt(req.opcode, req.funct3);
        w_word = 32'h0;
        case (w_fmt)
            FMT_R:   w_word = {req.funct7, req.rs2, req.rs1, req.funct3, req.rd, req.opcode};
            FMT_I:   w_word = {req.imm[11:0], req.rs1, req.funct3, req.rd, req.opcode};
            FMT_ISH: w_word = {req.funct7, req.imm[4:0], req.rs1, req.funct3, req.rd, req.opcode};
            FMT_S:   w_word = {req.imm[11:5], req.rs2, req.rs1, req.funct3, req.imm[4:0], req.opcode};
            FMT_B:   w_word = {req.imm[12], req.imm[10:5], req.rs2, req.rs1, req.funct3,
                               req.imm[4:1], req.imm[11], req.opcode};
            FMT_U:   w_word = {req.imm[31:12], req.rd, req.opcode};
            FMT_J:   w_word = {req.imm[20], req.imm[10:1], req.imm[11], req.imm[19:12],
                               req.rd, req.opcode};
            default: w_word = 32'h0;
        endcase
    end

    assign word = w_word;
    assign fmt  = w_fmt;

endmodule

`default_nettype wire

// File: rtl/instr_encode_writer.sv
// ============================================================================
// Module : instr_encode_writer
// Brief  : Encodes RV32I requests, buffers words in a FIFO and writes them to
//          memory at sequential addresses.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_encode_writer
    import instr_encode_writer_pkg::*;
#(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [6:0]  req_opcode,
    input  logic [2:0]  req_funct3,
    input  logic [6:0]  req_funct7,
    input  logic [4:0]  req_rd,
    input  logic [4:0]  req_rs1,
    input  logic [4:0]  req_rs2,
    input  logic [31:0] req_imm,
    input  logic        addr_load,
    input  logic [31:0] addr_in,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wdata,
    output logic        mem_write,
    output logic [3:0]  mem_byte_enable,
    input  logic        mem_resp,
    output logic        enc_err,
    output logic        busy,
    output logic [15:0] words_written
);

    localparam int c_aw = $clog2(DEPTH);

    localparam logic [0:0] c_st_idle  = 1'b0;
    localparam logic [0:0] c_st_write = 1'b1;

    encode_req_t w_req;
    logic [31:0] w_enc_word;
    instr_fmt_t  w_enc_fmt;

    assign w_req = '{opcode: req_opcode, funct3: req_funct3, funct7: req_funct7,
                     rd: req_rd, rs1: req_rs1, rs2: req_rs2, imm: req_imm};

    rv32i_encoder u_encoder (
        .req  (w_req),
        .word (w_enc_word),
        .fmt  (w_enc_fmt)
    );

    // FIFO: pointers carry one extra wrap bit to tell full from empty.
    logic [31:0]   r_fifo [DEPTH];
    logic [c_aw:0] r_wptr;
    logic [c_aw:0] r_rptr;
    logic          w_empty;
    logic          w_full;
    logic          w_accept;
    logic          w_push;
    logic          w_pop;

    assign w_empty  = (r_wptr == r_rptr);
    assign w_full   = (r_wptr[c_aw] != r_rptr[c_aw]) &&
                      (r_wptr[c_aw-1:0] == r_rptr[c_aw-1:0]);
    assign w_accept = req_valid && !w_full;
    assign w_push   = w_accept && (w_enc_fmt != FMT_BAD);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wptr[c_aw-1:0]] <= w_enc_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    // Write FSM
    logic [0:0]  r_state;
    logic [0:0]  w_state_nxt;
    logic        w_load;
    logic [31:0] r_next_addr;
    logic        r_pend;
    logic [31:0] r_pend_addr;
    logic [31:0] w_load_addr;
    logic [31:0] w_addr_eff;
    logic [31:0] r_mem_address;
    logic [31:0] r_mem_wdata;
    logic        r_enc_err;
    logic [15:0] r_words;

    assign w_load_addr = addr_in & 32'hFFFF_FFFC;
    assign w_addr_eff  = addr_load ? w_load_addr : r_next_addr;

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_pop       = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (!w_empty) begin
                    w_load      = 1'b1;
                    w_state_nxt = c_st_write;
                end
            end
            c_st_write: begin
                if (mem_resp) begin
                    w_pop       = 1'b1;
                    w_state_nxt = c_st_idle;
                end
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= c_st_idle;
            r_next_addr   <= BASE_ADDR;
            r_pend        <= 1'b0;
            r_pend_addr   <= 32'h0;
            r_mem_address <= 32'h0;
            r_mem_wdata   <= 32'h0;
            r_enc_err     <= 1'b0;
            r_words       <= 16'h0;
        end else begin
            r_state   <= w_state_nxt;
            r_enc_err <= w_accept && (w_enc_fmt == FMT_BAD);
            if (w_load) begin
                r_mem_address <= w_addr_eff;
                r_mem_wdata   <= r_fifo[r_rptr[c_aw-1:0]];
            end
            if (r_state == c_st_idle) begin
                r_pend <= 1'b0;
                if (addr_load) r_next_addr <= w_load_addr;
            end else if (mem_resp) begin
                // A same-cycle load beats a latched one, which beats +4.
                r_pend  <= 1'b0;
                r_words <= r_words + 16'h1;
                if (addr_load)   r_next_addr <= w_load_addr;
                else if (r_pend) r_next_addr <= r_pend_addr;
                else             r_next_addr <= r_next_addr + 32'h4;
            end else if (addr_load) begin
                r_pend      <= 1'b1;
                r_pend_addr <= w_load_addr;
            end
        end
    end

    assign req_ready       = !w_full;
    assign mem_address     = r_mem_address;
    assign mem_wdata       = r_mem_wdata;
    assign mem_write       = (r_state == c_st_write);
    assign mem_byte_enable = 4'hF;
    assign enc_err         = r_enc_err;
    assign busy            = !w_empty || (r_state == c_st_write);
    assign words_written   = r_words;

endmodule

`default_nettype wire
